// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift block.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    // Only mode 0 is supported: sclk idles low, data sampled on the leading edge.
    localparam bit CPOL = 1'b0;
    localparam bit CPHA = 1'b0;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_HALF_PERIOD = 1;

endpackage

// File: rtl/spi_master_shift_if.sv
// Handshake and SPI pin bundle for spi_master_shift.
interface spi_master_shift_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  start;
    logic [DATA_WIDTH-1:0] txData;
    logic [DATA_WIDTH-1:0] rxData;
    logic                  busy;
    logic                  done;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  csN;

    modport master (
        input  start, txData, miso,
        output rxData, busy, done, sclk, mosi, csN
    );

    modport slave (
        output start, txData, miso,
        input  rxData, busy, done, sclk, mosi, csN
    );
endinterface

// File: rtl/spi_half_period_tick.sv
// Down-counter that emits a one-cycle tick every HALF_PERIOD clocks.
// While clear is high the counter is held at its reload value and no tick is issued,
// so the first tick after clear drops arrives exactly HALF_PERIOD cycles later.
module spi_half_period_tick #(
    parameter int HALF_PERIOD = 1
) (
    input  logic clockIn,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt;

    // Reload on clear or terminal count, otherwise count down.
    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !clear;
endmodule

// File: rtl/spi_master_shift.sv
// Mode-0 SPI master: serialises txData MSB first on mosi, captures miso into rxData.
// The SHIFT state returns to TRAIL on the leading-edge tick after the last bit,
// so csN stays low for (2*DATA_WIDTH+2)*HALF_PERIOD cycles with DATA_WIDTH rising edges.
module spi_master_shift
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic               clockIn,
    input  logic               reset,
    spi_master_shift_if.master bus
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam bit SAMPLE_ON_LEAD = (CPHA == 1'b0);

    spi_state_t            state, state_n;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
    logic [DATA_WIDTH-1:0] rx_data, rx_data_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic                  sclk, sclk_n;
    logic                  mosi, mosi_n;
    logic                  cs_n, cs_n_n;
    logic                  busy, busy_n;
    logic                  done, done_n;
    logic                  tick;
    logic                  tick_clear;

    assign tick_clear = (state == IDLE);

    spi_half_period_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
        .clockIn (clockIn),
        .reset   (reset),
        .clear   (tick_clear),
        .tick    (tick)
    );

    // State and every output held in registers.
    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            bit_cnt  <= '0;
            sclk     <= CPOL;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            tx_shift <= tx_shift_n;
            rx_shift <= rx_shift_n;
            rx_data  <= rx_data_n;
            bit_cnt  <= bit_cnt_n;
            sclk     <= sclk_n;
            mosi     <= mosi_n;
            cs_n     <= cs_n_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n    = state;
        tx_shift_n = tx_shift;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        bit_cnt_n  = bit_cnt;
        sclk_n     = sclk;
        mosi_n     = mosi;
        cs_n_n     = cs_n;
        busy_n     = busy;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    tx_shift_n = bus.txData;
                    mosi_n     = bus.txData[DATA_WIDTH-1];
                    cs_n_n     = 1'b0;
                    busy_n     = 1'b1;
                    bit_cnt_n  = '0;
                    state_n    = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    sclk_n  = ~CPOL;
                    state_n = SHIFT;
                    if (SAMPLE_ON_LEAD) rx_shift_n = {rx_shift[DATA_WIDTH-2:0], bus.miso};
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk != CPOL) begin
                        sclk_n    = CPOL;
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (bit_cnt < BW'(DATA_WIDTH - 1)) begin
                            tx_shift_n = {tx_shift[DATA_WIDTH-2:0], 1'b0};
                            mosi_n     = tx_shift[DATA_WIDTH-2];
                        end
                    end else if (bit_cnt == BW'(DATA_WIDTH)) begin
                        state_n = TRAIL;
                    end else begin
                        sclk_n = ~CPOL;
                        if (SAMPLE_ON_LEAD) rx_shift_n = {rx_shift[DATA_WIDTH-2:0], bus.miso};
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    cs_n_n    = 1'b1;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    rx_data_n = rx_shift;
                    mosi_n    = 1'b0;
                    bit_cnt_n = '0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rxData = rx_data;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.sclk   = sclk;
    assign bus.mosi   = mosi;
    assign bus.csN    = cs_n;
endmodule
